// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
// No timing of its own; no flow control.
// Holds the run-state encoding and the smallest legal divisor.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_duty.sv
// Output stage: builds clk_out from the phase flop, stretching odd divisors to 50% duty.
// Latency: even divisors follow pos_q directly; odd divisors rise half a clk later.
// No backpressure; neg_q is the only falling-edge state in the design.
module clk_div_duty (
    input  logic clk,
    input  logic rst,
    input  logic pos_q,
    input  logic odd,
    output logic clk_out
);

    logic neg_q;

    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            neg_q <= 1'b0;
        else
            neg_q <= pos_q;
    end

    // AND of two flops trims the extra half cycle that ceil(D/2) leaves for odd D.
    assign clk_out = odd ? (pos_q & neg_q) : pos_q;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider with glitch-free start/stop and boundary-aligned reload.
// Latency: clk_out rises 1 clk after en is sampled; reloads take effect at the next period boundary.
// No backpressure; en is a level request and div_load a single-cycle strobe.
import clk_div_pkg::*;

module clk_div_prog #(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] div_val,
    input  logic         div_load,
    output logic         clk_out,
    output logic         tick,
    output logic         load_err,
    output logic [W-1:0] cur_div,
    output logic         active
);

    if (DEFAULT_DIV < MIN_DIV || DEFAULT_DIV >= (1 << W)) begin : g_bad_default
        $error("clk_div_prog: DEFAULT_DIV outside 2..2^W-1");
    end

    state_t       state, nxt_state;
    logic [W-1:0] cnt, nxt_cnt;
    logic [W-1:0] nxt_div;
    logic [W-1:0] pend_div, nxt_pend_div;
    logic         pend_vld, nxt_pend_vld;
    logic         pos_q, nxt_pos;
    logic         load_ok, boundary;
    logic [W:0]   nxt_half;

    assign load_ok  = div_load && (div_val >= W'(MIN_DIV));
    assign boundary = (state != IDLE) && (cnt == cur_div - W'(1));

    always_comb begin
        nxt_state    = state;
        nxt_cnt      = cnt;
        nxt_div      = cur_div;
        nxt_pend_div = pend_div;
        nxt_pend_vld = pend_vld;
        if (load_ok) begin
            nxt_pend_div = div_val;
            nxt_pend_vld = 1'b1;
        end
        case (state)
            IDLE: begin
                nxt_cnt = '0;
                // Nothing is running, so a load goes straight into force.
                if (load_ok) begin
                    nxt_div      = div_val;
                    nxt_pend_vld = 1'b0;
                end else if (pend_vld) begin
                    nxt_div      = pend_div;
                    nxt_pend_vld = 1'b0;
                end
                if (en)
                    nxt_state = RUN;
            end
            default: begin
                nxt_state = en ? RUN : STOPPING;
                if (boundary) begin
                    nxt_cnt = '0;
                    // A load landing on the boundary stays pending for the next one.
                    if (pend_vld) begin
                        nxt_div      = pend_div;
                        nxt_pend_vld = load_ok;
                    end
                    if (state == STOPPING && !en)
                        nxt_state = IDLE;
                end else begin
                    nxt_cnt = cnt + W'(1);
                end
            end
        endcase
    end

    assign nxt_half = ({1'b0, nxt_div} + (W+1)'(1)) >> 1;
    assign nxt_pos  = (nxt_state != IDLE) && ({1'b0, nxt_cnt} < nxt_half);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_div  <= W'(DEFAULT_DIV);
            pend_div <= '0;
            pend_vld <= 1'b0;
            pos_q    <= 1'b0;
            tick     <= 1'b0;
            load_err <= 1'b0;
            active   <= 1'b0;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            cur_div  <= nxt_div;
            pend_div <= nxt_pend_div;
            pend_vld <= nxt_pend_vld;
            pos_q    <= nxt_pos;
            tick     <= (nxt_state != IDLE) && (nxt_cnt == '0);
            load_err <= div_load && (div_val < W'(MIN_DIV));
            active   <= (nxt_state != IDLE);
        end
    end

    clk_div_duty u_duty (
        .clk     (clk),
        .rst     (rst),
        .pos_q   (pos_q),
        .odd     (cur_div[0]),
        .clk_out (clk_out)
    );

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios plus random en/load traffic against a period-level model.
module tb_clk_div_prog;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] div_val;
    logic       div_load;
    logic       clk_out;
    logic       tick;
    logic       load_err;
    logic [7:0] cur_div;
    logic       active;

    int n_tests = 0;
    int n_fail  = 0;
    int n_print = 0;

    // Reference: running flag, position in period, divisor in force, pending divisor (0 = none).
    int m_run, m_stop, m_pos, m_d, m_pend, m_lerr;

    clk_div_prog #(.W(8), .DEFAULT_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .load_err (load_err),
        .cur_div  (cur_div),
        .active   (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_print < 30) begin
                n_print++;
                $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
            end
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_stop = 0; m_pos = 0; m_d = 4; m_pend = 0; m_lerr = 0;
    endtask

    // Within a period of 2*D half-cycles, even D is high for the first D halves;
    // odd D starts half a cycle late and is high for D halves.
    function automatic logic exp_clk(input int h);
        int odd;
        odd = m_d % 2;
        return (m_run != 0) && (h >= odd) && (h < m_d + odd);
    endfunction

    task automatic model_step(input logic e, input logic ld, input int dv);
        logic ok;
        ok     = ld && (dv >= 2);
        m_lerr = (ld && dv < 2) ? 1 : 0;
        if (m_run == 0) begin
            if (ok) begin
                m_d = dv; m_pend = 0;
            end else if (m_pend != 0) begin
                m_d = m_pend; m_pend = 0;
            end
            if (e) begin
                m_run = 1; m_pos = 0;
            end
            m_stop = 0;
        end else begin
            if (m_pos == m_d - 1) begin
                m_pos = 0;
                if (m_pend != 0) begin
                    m_d = m_pend; m_pend = 0;
                end
                if (m_stop != 0 && !e) m_run = 0;
            end else begin
                m_pos++;
            end
            m_stop = e ? 0 : 1;
            if (ok) m_pend = dv;
        end
    endtask

    // Entered and left at negedge+1; compares every output against the model.
    task automatic cycle(input logic e, input logic ld, input int dv);
        en = e; div_load = ld; div_val = 8'(dv);
        @(posedge clk);
        model_step(e, ld, dv);
        #1;
        check("tick",     tick,     (m_run != 0 && m_pos == 0));
        check("active",   active,   m_run != 0);
        check("cur_div",  cur_div,  m_d);
        check("load_err", load_err, m_lerr != 0);
        check("clk_hi_half", clk_out, exp_clk(2 * m_pos));
        @(negedge clk);
        #1;
        check("clk_lo_half", clk_out, exp_clk(2 * m_pos + 1));
    endtask

    task automatic measure(input int n, input int exp_p);
        int last;
        last = -1;
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, 0);
            if (tick) begin
                if (last >= 0) check("period", i - last, exp_p);
                last = i;
            end
        end
    endtask

    task automatic wait_pos(input int d, input int p);
        int n;
        n = 0;
        while (!(m_run != 0 && m_d == d && m_pos == p) && n < 60) begin
            cycle(1'b1, 1'b0, 0);
            n++;
        end
        check("wait_pos_in_budget", n < 60, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clk_out"},  clk_out,  0);
        check({tag, "_tick"},     tick,     0);
        check({tag, "_load_err"}, load_err, 0);
        check({tag, "_active"},   active,   0);
        check({tag, "_cur_div"},  cur_div,  4);
    endtask

    initial begin
        logic en_r;
        int   dv;
        rst = 1'b1; en = 1'b0; div_val = 8'd0; div_load = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("rst");
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Idle with en low: nothing may start
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0);

        // Default divisor 4, first rise one clk after en
        measure(13, 4);

        // Reload to an odd divisor at the next boundary
        cycle(1'b1, 1'b1, 5);
        measure(20, 5);
        check("cur_div_after_5", cur_div, 5);

        // Rejected loads
        cycle(1'b1, 1'b1, 1);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b1, 0);
        measure(12, 5);

        // Back-to-back loads mid-period: last one wins
        wait_pos(5, 1);
        cycle(1'b1, 1'b1, 3);
        cycle(1'b1, 1'b1, 7);
        measure(25, 7);
        check("cur_div_after_7", cur_div, 7);

        // Stop at cnt=1 with D=6, then a stop/restart inside a period
        cycle(1'b1, 1'b1, 6);
        wait_pos(6, 1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 0);
        check("stopped_active", active, 0);
        check("stopped_clk", clk_out, 0);
        measure(8, 6);
        wait_pos(6, 3);
        cycle(1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 0);
        measure(20, 6);

        // Reset during a high phase at D=8, with a load pending
        cycle(1'b1, 1'b1, 8);
        wait_pos(8, 1);
        cycle(1'b1, 1'b1, 3);
        check("pre_rst_clk_high", clk_out, 1);
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("held_rst");
        @(negedge clk);
        #1;
        rst = 1'b0;
        measure(14, 4);
        check("cur_div_after_rst", cur_div, 4);

        // Random traffic
        en_r = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 29) == 0) en_r = ~en_r;
            if ($urandom_range(0, 199) == 0)
                dv = $urandom_range(2, 255);
            else if ($urandom_range(0, 7) == 0)
                dv = $urandom_range(0, 1);
            else
                dv = $urandom_range(2, 13);
            cycle(en_r, ($urandom_range(0, 11) == 0), dv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
